// File: rtl/sync_fifo_ext_pkg.sv
// Shared constants and helpers for the extended synchronous FIFO.
package sync_fifo_ext_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Number of address bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ext_if.sv
// Producer/consumer-facing bundle of the FIFO: write side, read side and status.
interface sync_fifo_ext_if
  import sync_fifo_ext_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int CNT_W = clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  // The user side drives requests and observes status.
  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // The FIFO side takes requests and reports status.
  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ext_ram.sv
// Storage array: one synchronous write port and one asynchronous read port.
module fifo_ram
  import sync_fifo_ext_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never cleared; only accepted writes update an entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags,
// synchronous flush and a choice of registered or fall-through read data.
module sync_fifo_ext
  import sync_fifo_ext_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_ext_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic [WIDTH-1:0] rd_data;
  logic             is_full;
  logic             is_empty;
  logic             rd_ok;
  logic             wr_ok;
  logic             ram_we;

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // A full FIFO still takes a write when the same edge pops an entry.
  assign rd_ok  = bus.rd_en & ~is_empty;
  assign wr_ok  = bus.wr_en & (~is_full | bus.rd_en);
  assign ram_we = wr_ok & rst_n & ~bus.flush;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers, occupancy and sticky errors; reset beats flush beats requests.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (bus.wr_en && !wr_ok) overflow_q  <= 1'b1;
      if (bus.rd_en && !rd_ok) underflow_q <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.dout = rd_data;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;

      // Registered read data; flush leaves the last value visible.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (!bus.flush && rd_ok) begin
          dout_q <= rd_data;
        end
      end

      assign bus.dout = dout_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Self-checking bench: a standard-mode and a fall-through FIFO share stimulus
// and are compared against a queue-based model plus hand-computed vectors.
module tb_sync_fifo_ext;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] din;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, sticky flags, registered read value.
  logic [WIDTH-1:0] mq[$];
  bit               m_ov;
  bit               m_uf;
  logic [WIDTH-1:0] m_dout;

  typedef struct {
    bit               rst_n;
    bit               flush;
    bit               wr;
    bit               rd;
    logic [WIDTH-1:0] din;
    int               exp_count;
    bit               exp_ov;
    bit               exp_uf;
    logic [WIDTH-1:0] exp_dout;
    logic [WIDTH-1:0] exp_head;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  sync_fifo_ext_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_std ();
  sync_fifo_ext_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_fw ();

  assign bus_std.flush = flush;
  assign bus_std.wr_en = wr_en;
  assign bus_std.rd_en = rd_en;
  assign bus_std.din   = din;
  assign bus_fw.flush  = flush;
  assign bus_fw.wr_en  = wr_en;
  assign bus_fw.rd_en  = rd_en;
  assign bus_fw.din    = din;

  sync_fifo_ext #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)
  ) dut_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_std.slave)
  );

  sync_fifo_ext #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)
  ) dut_fw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fw.slave)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic modelEdge();
    bit do_rd;
    bit do_wr;
    if (!rst_n) begin
      mq.delete();
      m_ov   = 1'b0;
      m_uf   = 1'b0;
      m_dout = '0;
    end else if (flush) begin
      mq.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
    end else begin
      do_rd = rd_en && (mq.size() != 0);
      do_wr = wr_en && ((mq.size() < DEPTH) || rd_en);
      if (rd_en && !do_rd) m_uf = 1'b1;
      if (wr_en && !do_wr) m_ov = 1'b1;
      if (do_rd) m_dout = mq.pop_front();
      if (do_wr) mq.push_back(din);
    end
  endtask

  // Compare both DUTs against the model state.
  task automatic checkOutput();
    int n;
    n = mq.size();
    checkVal("std.count", 32'(bus_std.count), 32'(n));
    checkVal("std.full", 32'(bus_std.full), 32'(n == DEPTH));
    checkVal("std.empty", 32'(bus_std.empty), 32'(n == 0));
    checkVal("std.almost_full", 32'(bus_std.almost_full), 32'(n >= AF));
    checkVal("std.almost_empty", 32'(bus_std.almost_empty), 32'(n <= AE));
    checkVal("std.overflow", 32'(bus_std.overflow), 32'(m_ov));
    checkVal("std.underflow", 32'(bus_std.underflow), 32'(m_uf));
    checkVal("std.dout", 32'(bus_std.dout), 32'(m_dout));
    checkVal("fw.count", 32'(bus_fw.count), 32'(n));
    checkVal("fw.full", 32'(bus_fw.full), 32'(n == DEPTH));
    checkVal("fw.empty", 32'(bus_fw.empty), 32'(n == 0));
    checkVal("fw.almost_full", 32'(bus_fw.almost_full), 32'(n >= AF));
    checkVal("fw.almost_empty", 32'(bus_fw.almost_empty), 32'(n <= AE));
    checkVal("fw.overflow", 32'(bus_fw.overflow), 32'(m_ov));
    checkVal("fw.underflow", 32'(bus_fw.underflow), 32'(m_uf));
    if (n > 0) checkVal("fw.dout_head", 32'(bus_fw.dout), 32'(mq[0]));
  endtask

  // Present one cycle of inputs, clock it, then check away from the edge.
  task automatic applyStimulus(input bit r, input bit f, input bit w, input bit rd,
                               input logic [WIDTH-1:0] d);
    rst_n = r;
    flush = f;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // rst, flush, wr, rd, din, count, ov, uf, std dout, fwft head
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00, 8'h11};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h00, 8'h11};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h11, 8'h22};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b0, 8'h22, 8'h33};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h33, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h33, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b1, 8'h33, 8'h55};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 0, 1'b0, 1'b0, 8'h33, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h33, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00};

    rst_n = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    $display("[TB] reset");
    doReset();
    checkVal("reset.std.dout", 32'(bus_std.dout), 32'h0);
    checkVal("reset.std.almost_empty", 32'(bus_std.almost_empty), 32'h1);

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].rst_n, tbl[i].flush, tbl[i].wr, tbl[i].rd, tbl[i].din);
      checkVal($sformatf("vec%0d.count", i), 32'(bus_std.count), 32'(tbl[i].exp_count));
      checkVal($sformatf("vec%0d.fw_count", i), 32'(bus_fw.count), 32'(tbl[i].exp_count));
      checkVal($sformatf("vec%0d.overflow", i), 32'(bus_std.overflow), 32'(tbl[i].exp_ov));
      checkVal($sformatf("vec%0d.underflow", i), 32'(bus_std.underflow), 32'(tbl[i].exp_uf));
      checkVal($sformatf("vec%0d.dout", i), 32'(bus_std.dout), 32'(tbl[i].exp_dout));
      if (tbl[i].exp_count > 0)
        checkVal($sformatf("vec%0d.fw_head", i), 32'(bus_fw.dout), 32'(tbl[i].exp_head));
    end

    $display("[TB] fill, overflow, drain");
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hAA);
    checkVal("ovf.overflow", 32'(bus_std.overflow), 32'h1);
    checkVal("ovf.count", 32'(bus_std.count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      checkVal("drain.dout_seq", 32'(bus_std.dout), 32'(i));
    end
    checkVal("drain.empty", 32'(bus_std.empty), 32'h1);

    $display("[TB] pointer wrap");
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checkVal("wrap.last", 32'(bus_std.dout), 32'h77);
    checkVal("wrap.count", 32'(bus_std.count), 32'h0);
    checkVal("wrap.flags", {30'h0, bus_std.overflow, bus_std.underflow}, 32'h0);

    $display("[TB] simultaneous read/write");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(i * 3));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h99);
    checkVal("simfull.count", 32'(bus_std.count), 32'd16);
    checkVal("simfull.overflow", 32'(bus_std.overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checkVal("simfull.last", 32'(bus_std.dout), 32'h99);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    checkVal("simempty.count", 32'(bus_std.count), 32'd1);
    checkVal("simempty.underflow", 32'(bus_std.underflow), 32'h1);
    checkVal("simempty.fw_head", 32'(bus_fw.dout), 32'h55);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checkVal("simempty.read", 32'(bus_std.dout), 32'h55);

    $display("[TB] flush");
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h12);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h34);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h56);
    checkVal("flush.count", 32'(bus_std.count), 32'h0);
    checkVal("flush.empty", 32'(bus_fw.empty), 32'h1);

    $display("[TB] fall-through head");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
    checkVal("fwft.head", 32'(bus_fw.dout), 32'h3C);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checkVal("fwft.pop_empty", 32'(bus_fw.empty), 32'h1);

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 9) < 5),
                    8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
